// File: rtl/mul_div_issue_wb.sv
// Issue and in-order writeback stage for the stream MUL/DIV unit.
// Define MUL_DIV_X0_DROP_EN to silently retire results whose destination is x0.
module mul_div_issue_wb #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  output logic        core_ack_o,
  input  logic [31:0] core_instr_code_bi,
  input  logic [31:0] core_src0_bi,
  input  logic [31:0] core_src1_bi,
  input  logic [4:0]  core_rd_addr_bi,
  output logic        exu_req_o,
  output logic [31:0] exu_instr_code_bo,
  output logic [31:0] exu_src0_bo,
  output logic [31:0] exu_src1_bo,
  input  logic        exu_ack_i,
  input  logic        exu_resp_req_i,
  input  logic [31:0] exu_resp_wdata_bi,
  output logic        exu_resp_ack_o,
  output logic        wb_req_o,
  output logic [4:0]  wb_rd_addr_bo,
  output logic [31:0] wb_wdata_bo,
  input  logic        wb_ack_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic          req_valid;
  logic [31:0]   req_instr, req_src0, req_src1;
  logic [CW-1:0] cnt;
  logic          core_accept, exu_hs, wb_pop, pop, drop_pop;

  logic [CW-1:0] tag_wptr, tag_rptr, res_wptr, res_rptr;
  logic [CW-1:0] tag_count, res_count;
  logic [4:0]    tag_mem [DEPTH];
  logic [31:0]   res_mem [DEPTH];
  logic          tag_empty, tag_full, res_empty, res_full;
  logic [4:0]    tag_head;
  logic [31:0]   res_head;

  assign core_ack_o     = (cnt < DEPTH_C) && (!req_valid || exu_ack_i);
  assign core_accept    = core_req_i && core_ack_o;
  assign exu_hs         = req_valid && exu_ack_i;
  assign exu_req_o      = req_valid;
  assign exu_instr_code_bo = req_instr;
  assign exu_src0_bo    = req_src0;
  assign exu_src1_bo    = req_src1;
  assign exu_resp_ack_o = 1'b1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign tag_empty = (tag_wptr == tag_rptr);
  assign tag_full  = (tag_wptr[AW] != tag_rptr[AW]) && (tag_wptr[AW-1:0] == tag_rptr[AW-1:0]);
  assign res_empty = (res_wptr == res_rptr);
  assign res_full  = (res_wptr[AW] != res_rptr[AW]) && (res_wptr[AW-1:0] == res_rptr[AW-1:0]);
  assign tag_count = tag_wptr - tag_rptr;
  assign res_count = res_wptr - res_rptr;
  assign tag_head  = tag_empty ? '0 : tag_mem[tag_rptr[AW-1:0]];
  assign res_head  = res_empty ? '0 : res_mem[res_rptr[AW-1:0]];

`ifdef MUL_DIV_X0_DROP_EN
  logic x0_head, drop_q;
  assign x0_head  = !res_empty && (tag_head == 5'd0);
  // The x0 entry sits at the head for one cycle, then is retired without a writeback.
  always_ff @(posedge clk_i) begin
    if (rst_i) drop_q <= 1'b0;
    else       drop_q <= x0_head && !drop_q;
  end
  assign drop_pop = drop_q;
  assign wb_req_o = !res_empty && !x0_head;
`else
  assign drop_pop = 1'b0;
  assign wb_req_o = !res_empty;
`endif

  assign wb_rd_addr_bo = tag_head;
  assign wb_wdata_bo   = res_head;
  assign wb_pop        = wb_req_o && wb_ack_i;
  assign pop           = wb_pop || drop_pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_valid <= 1'b0;
      req_instr <= '0;
      req_src0  <= '0;
      req_src1  <= '0;
    end else if (core_accept) begin
      req_valid <= 1'b1;
      req_instr <= core_instr_code_bi;
      req_src0  <= core_src0_bi;
      req_src1  <= core_src1_bi;
    end else if (exu_hs) begin
      req_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt <= '0;
    else begin
      case ({core_accept, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_wptr <= '0;
      tag_rptr <= '0;
      res_wptr <= '0;
      res_rptr <= '0;
    end else begin
      if (core_accept && !tag_full)    tag_wptr <= tag_wptr + CW'(1);
      if (pop && !tag_empty)           tag_rptr <= tag_rptr + CW'(1);
      if (exu_resp_req_i && !res_full) res_wptr <= res_wptr + CW'(1);
      if (pop && !res_empty)           res_rptr <= res_rptr + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && core_accept && !tag_full)    tag_mem[tag_wptr[AW-1:0]] <= core_rd_addr_bi;
    if (!rst_i && exu_resp_req_i && !res_full) res_mem[res_wptr[AW-1:0]] <= exu_resp_wdata_bi;
  end

  a_occupancy: assert property (@(posedge clk_i) disable iff (rst_i)
    (res_count <= tag_count) && (tag_count <= cnt) && (cnt <= DEPTH_C));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(core_accept && tag_full) && !(exu_resp_req_i && res_full));
  a_resp_unmatched: assert property (@(posedge clk_i) disable iff (rst_i)
    exu_resp_req_i |-> (res_count < tag_count));
endmodule

// File: tb/tb_mul_div_issue_wb.sv
// Directed bench for mul_div_issue_wb: behavioural EXU responder, in-order scoreboard, literal checks.
module tb_mul_div_issue_wb;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam logic [31:0] MUL_INSTR = 32'h0200_0033;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, core_req_i, core_ack_o, exu_req_o, exu_ack_i;
  logic [31:0] core_instr_code_bi, core_src0_bi, core_src1_bi;
  logic [4:0]  core_rd_addr_bi, wb_rd_addr_bo;
  logic [31:0] exu_instr_code_bo, exu_src0_bo, exu_src1_bo, exu_resp_wdata_bi, wb_wdata_bo;
  logic        exu_resp_req_i, exu_resp_ack_o, wb_req_o, wb_ack_i;

  mul_div_issue_wb #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_ack_o(core_ack_o),
    .core_instr_code_bi(core_instr_code_bi), .core_src0_bi(core_src0_bi),
    .core_src1_bi(core_src1_bi), .core_rd_addr_bi(core_rd_addr_bi),
    .exu_req_o(exu_req_o), .exu_instr_code_bo(exu_instr_code_bo),
    .exu_src0_bo(exu_src0_bo), .exu_src1_bo(exu_src1_bo), .exu_ack_i(exu_ack_i),
    .exu_resp_req_i(exu_resp_req_i), .exu_resp_wdata_bi(exu_resp_wdata_bi),
    .exu_resp_ack_o(exu_resp_ack_o),
    .wb_req_o(wb_req_o), .wb_rd_addr_bo(wb_rd_addr_bo), .wb_wdata_bo(wb_wdata_bo),
    .wb_ack_i(wb_ack_i)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Execution unit: answers each accepted request with src0*src1 after LAT cycles, in order.
  typedef struct { int due; logic [31:0] v; } rsp_t;
  rsp_t pend[$];
  always @(negedge clk) begin
    if (rst_i) pend.delete();
    else if (exu_req_o && exu_ack_i) pend.push_back('{cyc + LAT, exu_src0_bo * exu_src1_bo});
  end
  initial begin
    exu_resp_req_i = 1'b0;
    exu_resp_wdata_bi = '0;
    forever begin
      @(posedge clk); #1;
      exu_resp_req_i = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        exu_resp_req_i = 1'b1;
        exu_resp_wdata_bi = pend[0].v;
        void'(pend.pop_front());
      end
    end
  end

  // Reference model: outstanding ops in order, each expected to write back {rd, src0*src1}.
  typedef struct { logic [31:0] ic, s0, s1; } op_t;
  op_t         issue_q[$];
  logic [4:0]  tag_q[$];
  logic [31:0] val_q[$];
  logic [4:0]  log_rd[$];
  logic [31:0] log_data[$];
  int res_n = 0, m_cnt = 0, age = 0;

  always @(negedge clk) begin
    if (started) begin
      logic exp_ack, exp_wb, drop_head, acc, hs, popw, drop;
      exp_wb = (res_n > 0);
      drop_head = 1'b0;
`ifdef MUL_DIV_X0_DROP_EN
      if (res_n > 0 && tag_q[0] == 5'd0) begin exp_wb = 1'b0; drop_head = 1'b1; end
`endif
      exp_ack = (m_cnt < DEPTH) && (issue_q.size() == 0 || exu_ack_i);
      chk("core_ack", {31'b0, core_ack_o}, {31'b0, exp_ack});
      chk("exu_req", {31'b0, exu_req_o}, {31'b0, issue_q.size() != 0});
      chk("wb_req", {31'b0, wb_req_o}, {31'b0, exp_wb});
      chk("resp_ack", {31'b0, exu_resp_ack_o}, 32'd1);
      if (issue_q.size() != 0) begin
        chk("exu_instr", exu_instr_code_bo, issue_q[0].ic);
        chk("exu_src0", exu_src0_bo, issue_q[0].s0);
        chk("exu_src1", exu_src1_bo, issue_q[0].s1);
      end
      if (exp_wb) begin
        chk("wb_rd", {27'b0, wb_rd_addr_bo}, {27'b0, tag_q[0]});
        chk("wb_data", wb_wdata_bo, val_q[0]);
      end
      if (rst_i) begin
        issue_q.delete(); tag_q.delete(); val_q.delete();
        res_n = 0; m_cnt = 0; age = 0;
      end else begin
        acc  = core_req_i && exp_ack;
        hs   = (issue_q.size() != 0) && exu_ack_i;
        popw = exp_wb && wb_ack_i;
        drop = 1'b0;
        if (drop_head) begin
          if (age == 1) begin drop = 1'b1; age = 0; end
          else age = 1;
        end else age = 0;
        if (popw) begin log_rd.push_back(wb_rd_addr_bo); log_data.push_back(wb_wdata_bo); end
        if (popw || drop) begin
          void'(tag_q.pop_front()); void'(val_q.pop_front());
          res_n--; m_cnt--;
        end
        if (hs) void'(issue_q.pop_front());
        if (acc) begin
          issue_q.push_back('{core_instr_code_bi, core_src0_bi, core_src1_bi});
          tag_q.push_back(core_rd_addr_bi);
          val_q.push_back(core_src0_bi * core_src1_bi);
          m_cnt++;
        end
        if (exu_resp_req_i) res_n++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    bit got;
    got = 0;
    core_req_i = 1'b1; core_instr_code_bi = MUL_INSTR;
    core_src0_bi = a; core_src1_bi = b; core_rd_addr_bi = rd;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); got = core_ack_o;
      @(posedge clk); #1;
      if (got) break;
    end
    core_req_i = 1'b0;
    if (!got) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (tag_q.size() == 0) begin done = 1; break; end
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_core_ack"}, {31'b0, core_ack_o}, 32'd1);
    chk({tag, "_exu_req"}, {31'b0, exu_req_o}, 32'd0);
    chk({tag, "_wb_req"}, {31'b0, wb_req_o}, 32'd0);
    chk({tag, "_exu_instr"}, exu_instr_code_bo, 32'd0);
    chk({tag, "_exu_src0"}, exu_src0_bo, 32'd0);
    chk({tag, "_exu_src1"}, exu_src1_bo, 32'd0);
    chk({tag, "_wb_rd"}, {27'b0, wb_rd_addr_bo}, 32'd0);
    chk({tag, "_wb_data"}, wb_wdata_bo, 32'd0);
    chk({tag, "_resp_ack"}, {31'b0, exu_resp_ack_o}, 32'd1);
  endtask

  initial begin
    int base;
    logic [4:0]  exp_rd [4];
    logic [31:0] exp_v  [4];
    rst_i = 1'b1; core_req_i = 1'b0; core_instr_code_bi = '0; core_src0_bi = '0;
    core_src1_bi = '0; core_rd_addr_bi = '0; exu_ack_i = 1'b1; wb_ack_i = 1'b1;
    tick(2);
    started = 1;
    reset_vals("reset");
    @(posedge clk); #1; rst_i = 1'b0;

    // Single MUL 7*6 -> rd5 = 42
    base = log_rd.size();
    issue(5'd5, 32'd7, 32'd6);
    wait_drain();
    chk("single_count", log_rd.size() - base, 32'd1);
    if (log_rd.size() > base) begin
      chk("single_rd", {27'b0, log_rd[base]}, 32'd5);
      chk("single_data", log_data[base], 32'd42);
    end
    @(negedge clk); chk("single_cnt_zero", {31'b0, core_ack_o}, 32'd1);
    @(posedge clk); #1;

    // Credit exhaustion and ordering
    base = log_rd.size();
    wb_ack_i = 1'b0;
    for (int i = 1; i <= 4; i++) issue(5'(i), 32'h11 * i, 32'd1);
    tick(6);
    @(negedge clk); chk("credit_full", {31'b0, core_ack_o}, 32'd0);
    @(posedge clk); #1; wb_ack_i = 1'b1;
    @(posedge clk); #1; wb_ack_i = 1'b0;
    @(negedge clk); chk("credit_return", {31'b0, core_ack_o}, 32'd1);
    @(posedge clk); #1; wb_ack_i = 1'b1;
    wait_drain();
    exp_rd = '{5'd1, 5'd2, 5'd3, 5'd4};
    exp_v  = '{32'h11, 32'h22, 32'h33, 32'h44};
    chk("order_count", log_rd.size() - base, 32'd4);
    for (int i = 0; i < 4; i++)
      if (log_rd.size() > base + i) begin
        chk("order_rd", {27'b0, log_rd[base+i]}, {27'b0, exp_rd[i]});
        chk("order_data", log_data[base+i], exp_v[i]);
      end

    // EXU stall with a second op waiting
    base = log_rd.size();
    exu_ack_i = 1'b0;
    issue(5'd7, 32'd3, 32'd9);
    core_req_i = 1'b1; core_src0_bi = 32'd2; core_src1_bi = 32'd5; core_rd_addr_bi = 5'd8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_core_ack", {31'b0, core_ack_o}, 32'd0);
      chk("stall_exu_req", {31'b0, exu_req_o}, 32'd1);
      chk("stall_src0", exu_src0_bo, 32'd3);
      chk("stall_src1", exu_src1_bo, 32'd9);
    end
    @(posedge clk); #1; exu_ack_i = 1'b1;
    @(negedge clk); chk("stall_release_ack", {31'b0, core_ack_o}, 32'd1);
    @(posedge clk); #1; core_req_i = 1'b0;
    wait_drain();
    chk("stall_count", log_rd.size() - base, 32'd2);
    if (log_rd.size() >= base + 2) begin
      chk("stall_rd0", {27'b0, log_rd[base]}, 32'd7);
      chk("stall_data0", log_data[base], 32'd27);
      chk("stall_rd1", {27'b0, log_rd[base+1]}, 32'd8);
      chk("stall_data1", log_data[base+1], 32'd10);
    end

    // Back-to-back stream, 3*DEPTH+1 ops: overlaps hand-off, accept and pop; wraps FIFOs
    base = log_rd.size();
    for (int i = 0; i < 3 * DEPTH + 1; i++) issue(5'(i + 1), 32'(i + 2), 32'(i + 3));
    wait_drain();
    chk("stream_count", log_rd.size() - base, 32'(3 * DEPTH + 1));
    if (log_rd.size() >= base + 3 * DEPTH + 1) begin
      chk("stream_last_rd", {27'b0, log_rd[base + 3*DEPTH]}, 32'd13);
      chk("stream_last_data", log_data[base + 3*DEPTH], 32'd210);
    end

    // Destination x0
    base = log_rd.size();
    issue(5'd0, 32'd4, 32'd5);
    wait_drain();
`ifdef MUL_DIV_X0_DROP_EN
    chk("x0_dropped", log_rd.size() - base, 32'd0);
`else
    chk("x0_count", log_rd.size() - base, 32'd1);
    if (log_rd.size() > base) begin
      chk("x0_rd", {27'b0, log_rd[base]}, 32'd0);
      chk("x0_data", log_data[base], 32'd20);
    end
`endif
    @(negedge clk); chk("x0_credit", {31'b0, core_ack_o}, 32'd1);
    @(posedge clk); #1;

    // Reset with three ops in flight
    wb_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) issue(5'(20 + i), 32'(i + 1), 32'd3);
    tick(1);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    reset_vals("midreset");
    @(posedge clk); #1; wb_ack_i = 1'b1;
    tick(6);
    @(negedge clk); chk("post_reset_idle", {31'b0, wb_req_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
